// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift/rotate unit:
// op codes, FSM state enum and the count-width helper.
package shift_pkg;

    localparam logic [2:0] OP_SHL  = 3'd0;
    localparam logic [2:0] OP_SHR  = 3'd1;
    localparam logic [2:0] OP_SHRA = 3'd2;
    localparam logic [2:0] OP_ROL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to hold 0..w inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_rotate_unit_step.sv
// Combinational single step: shifts/rotates val_i by k_i (<= STEP) bits.
// Ports: val_i, op_i, k_i in; res_o (new value), cout_o (last bit out) out.
import shift_pkg::*;

module shift_step #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic [2:0]       op_i,
    input  logic [CW-1:0]    k_i,
    output logic [WIDTH-1:0] res_o,
    output logic             cout_o
);

    // One extra bit on the exit side catches the last bit shifted out;
    // with k_i == 0 that bit is the zero pad, so carry is 0.
    logic [WIDTH:0]   l_ext;
    logic [WIDTH:0]   r_ext;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] ror_v;
    int               sh;

    always_comb begin
        sh     = int'(k_i);
        l_ext  = {1'b0, val_i} << k_i;
        r_ext  = {val_i, 1'b0} >> k_i;
        a_ext  = $signed({val_i, 1'b0}) >>> k_i;
        rol_v  = (val_i << k_i) | (val_i >> (WIDTH - sh));
        ror_v  = (val_i >> k_i) | (val_i << (WIDTH - sh));
        if (k_i == '0) begin
            rol_v = val_i;
            ror_v = val_i;
        end
        res_o  = val_i;
        cout_o = 1'b0;
        case (op_i)
            OP_SHL: begin
                res_o  = l_ext[WIDTH-1:0];
                cout_o = l_ext[WIDTH];
            end
            OP_SHR: begin
                res_o  = r_ext[WIDTH:1];
                cout_o = r_ext[0];
            end
            OP_SHRA: begin
                res_o  = a_ext[WIDTH:1];
                cout_o = a_ext[0];
            end
            OP_ROL: begin
                res_o  = rol_v;
                cout_o = l_ext[WIDTH];
            end
            OP_ROR: begin
                res_o  = ror_v;
                cout_o = r_ext[0];
            end
            default: begin
                res_o  = val_i;
                cout_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// Iterative shift/rotate engine: accept on start, shift up to STEP bits per cycle.
// Ports: clock, clear (async low), start, op, a, b in; busy, done, result, carry out.
import shift_pkg::*;

module shift_rotate_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int CW = cnt_w(WIDTH);
    localparam int LW = $clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;

    logic [CW-1:0]    amt_d;
    logic [CW-1:0]    k_d;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] acc_d;
    logic             carry_d;

    // Shifts saturate at WIDTH using the full b; rotates wrap mod WIDTH.
    always_comb begin
        amt_d = '0;
        case (op)
            OP_SHL, OP_SHR, OP_SHRA:
                amt_d = (b >= WIDTH'(WIDTH)) ? CW'(WIDTH) : b[CW-1:0];
            OP_ROL, OP_ROR:
                amt_d = CW'(b[LW-1:0]);
            default:
                amt_d = '0;
        endcase
    end

    always_comb begin
        k_d   = (cnt_q > CW'(STEP)) ? CW'(STEP) : cnt_q;
        cnt_d = cnt_q - k_d;
    end

    shift_step #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_step (
        .val_i  (acc_q),
        .op_i   (op_q),
        .k_i    (k_d),
        .res_o  (acc_d),
        .cout_o (carry_d)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state_q <= IDLE;
                    if (start) begin
                        acc_q   <= a;
                        cnt_q   <= amt_d;
                        op_q    <= op;
                        carry_q <= 1'b0;
                        if (amt_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = acc_q;
    assign carry  = carry_q;

endmodule
